// File: rtl/dtt_xbar_pkg.sv
// dtt_xbar_pkg: shared crossbar beat width and beat type for the crossbar and its egress buffers.
package dtt_xbar_pkg;
    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] dtt_beat_t;
endpackage

// File: rtl/dtt_egress_fifo_mem.sv
// dtt_egress_fifo_mem: DEPTH x DATA_WIDTH storage, one write port, asynchronous read port.
module dtt_egress_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/dtt_xbar_egress_buffer.sv
// dtt_xbar_egress_buffer: captures no-backpressure crossbar beats into a show-ahead FIFO, drops on full.
// Optional statistics counters are enabled by defining DTT_EGRESS_STATS_EN.
module dtt_xbar_egress_buffer
    import dtt_xbar_pkg::*;
#(
    parameter int DATA_WIDTH   = dtt_xbar_pkg::DATA_WIDTH,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
`ifdef DTT_EGRESS_STATS_EN
   ,parameter int CNT_W        = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     xbar_valid,
    input  logic [DATA_WIDTH-1:0]    xbar_data,
    input  logic                     flush,
    output logic                     m_valid,
    output logic [DATA_WIDTH-1:0]    m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     drop_pulse
`ifdef DTT_EGRESS_STATS_EN
   ,output logic [CNT_W-1:0]         rx_count,
    output logic [CNT_W-1:0]         drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr, rd, wr_nxt, rd_nxt, lvl_nxt;
    logic [DATA_WIDTH-1:0] rdata;
    logic empty, full, pop, push, drop;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    assign empty   = wr == rd;
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign m_valid = !empty;
    assign m_data  = empty ? '0 : rdata;
    assign pop     = m_valid && m_ready;
    assign push    = xbar_valid && (!full || pop);
    assign drop    = xbar_valid && full && !pop;
    assign level   = wr - rd;
    assign wr_nxt  = flush ? '0 : wr + PW'(push);
    assign rd_nxt  = flush ? '0 : rd + PW'(pop);
    assign lvl_nxt = wr_nxt - rd_nxt;

    dtt_egress_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr[AW-1:0]),
        .wdata (xbar_data),
        .raddr (rd[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr          <= '0;
            rd          <= '0;
            almost_full <= 1'b0;
            drop_pulse  <= 1'b0;
        end else begin
            wr          <= wr_nxt;
            rd          <= rd_nxt;
            almost_full <= lvl_nxt >= PW'(AFULL_THRESH);
            drop_pulse  <= drop && !flush;
        end
    end

`ifdef DTT_EGRESS_STATS_EN
    // Saturating counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            rx_count   <= (push && !flush && !(&rx_count)) ? rx_count + CNT_W'(1) : rx_count;
            drop_count <= (drop && !flush && !(&drop_count)) ? drop_count + CNT_W'(1) : drop_count;
        end
    end
`endif
endmodule
